// File: rtl/flash_write_if.sv
// ============================================================================
// flash_write_if
// Client handshake and serial flash bus bundle for the flash_write programmer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface flash_write_if;
  logic        start;
  logic        erase;
  logic [23:0] addrin;
  logic [8:0]  length;
  logic [7:0]  din;
  logic        data_req;
  logic [7:0]  data_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic        cclk;
  logic        cs_b;
  logic        mosi;
  logic        miso;

  modport master (
    output start, erase, addrin, length, din, miso,
    input  data_req, data_addr, busy, done, err, cclk, cs_b, mosi
  );

  modport slave (
    input  start, erase, addrin, length, din, miso,
    output data_req, data_addr, busy, done, err, cclk, cs_b, mosi
  );
endinterface

`default_nettype wire

// File: rtl/flash_write.sv
// ============================================================================
// flash_write
// SPI flash programmer: WREN, then page program or 64 KiB sector erase, then
// status polling until WIP clears or the poll budget runs out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module flash_write #(
  parameter int          CS_GAP     = 4,
  parameter logic [23:0] POLL_LIMIT = 24'hFFFFFF
) (
  input  logic         clk,
  input  logic         rst,
  flash_write_if.slave bus
);

  // Bit 2 marks every chip-select-active state, so cs_b is a single flop bit.
  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_GAP1 = 3'b001,
    S_GAP2 = 3'b010,
    S_WREN = 3'b100,
    S_CMD  = 3'b101,
    S_DATA = 3'b110,
    S_POLL = 3'b111
  } state_t;

  state_t      state, state_n;
  logic [31:0] sr, sr_n;
  logic [7:0]  cnt, cnt_n;
  logic [8:0]  left, left_n;
  logic [7:0]  req_idx, req_idx_n;
  logic [23:0] addr_q, addr_n;
  logic        erase_q, erase_n;
  logic        status_ph, status_ph_n;
  logic [23:0] poll_cnt, poll_cnt_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic        err_q, err_n;
  logic        mosi_c, data_req_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sr        <= '0;
      cnt       <= '0;
      left      <= '0;
      req_idx   <= '0;
      addr_q    <= '0;
      erase_q   <= 1'b0;
      status_ph <= 1'b0;
      poll_cnt  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      left      <= left_n;
      req_idx   <= req_idx_n;
      addr_q    <= addr_n;
      erase_q   <= erase_n;
      status_ph <= status_ph_n;
      poll_cnt  <= poll_cnt_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    left_n      = left;
    req_idx_n   = req_idx;
    addr_n      = addr_q;
    erase_n     = erase_q;
    status_ph_n = status_ph;
    poll_cnt_n  = poll_cnt;
    busy_n      = busy_q;
    done_n      = 1'b0;
    err_n       = 1'b0;
    mosi_c      = 1'b0;
    data_req_c  = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (!bus.erase && (bus.length == 9'd0 || bus.length > 9'd256)) begin
            err_n = 1'b1;
          end else begin
            state_n   = S_WREN;
            busy_n    = 1'b1;
            erase_n   = bus.erase;
            addr_n    = bus.addrin;
            left_n    = bus.length;
            req_idx_n = '0;
            sr_n      = {8'h06, 24'h0};
            cnt_n     = 8'd7;
          end
        end
      end
      S_WREN: begin
        mosi_c = sr[31];
        sr_n   = {sr[30:0], 1'b0};
        cnt_n  = cnt - 8'd1;
        if (cnt == 8'd0) begin
          state_n = S_GAP1;
          cnt_n   = 8'(CS_GAP - 1);
        end
      end
      S_GAP1: begin
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd0) begin
          state_n = S_CMD;
          cnt_n   = 8'd31;
          sr_n    = {(erase_q ? 8'hD8 : 8'h02), addr_q};
        end
      end
      S_CMD: begin
        mosi_c     = sr[31];
        sr_n       = {sr[30:0], 1'b0};
        cnt_n      = cnt - 8'd1;
        // Byte 0 is requested two bits early so it lands right after the address.
        data_req_c = !erase_q && (cnt == 8'd1);
        if (cnt == 8'd0) begin
          if (erase_q) begin
            state_n = S_GAP2;
            cnt_n   = 8'(CS_GAP - 1);
          end else begin
            state_n = S_DATA;
            sr_n    = {bus.din, 24'h0};
            cnt_n   = 8'd7;
            left_n  = left - 9'd1;
          end
        end
      end
      S_DATA: begin
        mosi_c     = sr[31];
        sr_n       = {sr[30:0], 1'b0};
        cnt_n      = cnt - 8'd1;
        data_req_c = (cnt == 8'd1) && (left != 9'd0);
        if (cnt == 8'd0) begin
          if (left != 9'd0) begin
            sr_n   = {bus.din, 24'h0};
            cnt_n  = 8'd7;
            left_n = left - 9'd1;
          end else begin
            state_n = S_GAP2;
            cnt_n   = 8'(CS_GAP - 1);
          end
        end
      end
      S_GAP2: begin
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd0) begin
          state_n     = S_POLL;
          sr_n        = {8'h05, 24'h0};
          cnt_n       = 8'd7;
          status_ph_n = 1'b0;
          poll_cnt_n  = '0;
        end
      end
      S_POLL: begin
        cnt_n = cnt - 8'd1;
        if (!status_ph) begin
          mosi_c = sr[31];
          sr_n   = {sr[30:0], 1'b0};
          if (cnt == 8'd0) begin
            status_ph_n = 1'b1;
            cnt_n       = 8'd7;
          end
        end else if (cnt == 8'd0) begin
          // The eighth sample of each status byte is WIP (bit0).
          cnt_n = 8'd7;
          if (!bus.miso) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else if (poll_cnt + 24'd1 == POLL_LIMIT) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
            busy_n  = 1'b0;
          end else begin
            poll_cnt_n = poll_cnt + 24'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (data_req_c) req_idx_n = req_idx + 8'd1;
  end

  assign bus.cs_b      = ~state[2];
  assign bus.mosi      = mosi_c;
  assign bus.data_req  = data_req_c;
  assign bus.data_addr = req_idx;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.cclk      = ~clk;

endmodule

`default_nettype wire

// File: tb/tb_flash_write.sv
// ============================================================================
// tb_flash_write
// Directed bench for flash_write with a byte RAM and a serial flash model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_flash_write;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flash_write_if bus ();
  flash_write_if bus2 ();

  flash_write u_dut (.clk(clk), .rst(rst), .bus(bus));
  flash_write #(.POLL_LIMIT(24'd4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ram [4];
  int          wip_bytes = 0;
  logic        clr = 1'b0;

  logic [63:0] cur;
  int          bitpos;
  logic [7:0]  first8;
  logic [63:0] win_data [8];
  int          win_len [8];
  int          win_count, req_count, done_count, err_count, bad_pulse;
  logic [7:0]  req_addr [8];

  // Block-RAM style read: one cycle of latency after data_req.
  always @(posedge clk) if (bus.data_req) bus.din <= ram[bus.data_addr[1:0]];

  // Flash model and bus monitor, both observed mid-cycle.
  always @(negedge clk) begin
    if (clr) begin
      win_count <= 0; req_count <= 0; done_count <= 0; err_count <= 0; bad_pulse <= 0;
    end else begin
      if (bus.data_req && req_count < 8) begin
        req_addr[req_count] <= bus.data_addr;
        req_count <= req_count + 1;
      end
      if (bus.done) done_count <= done_count + 1;
      if (bus.err) err_count <= err_count + 1;
      if ((bus.done && bus.err) || ((bus.done || bus.err) && bus.busy)) bad_pulse <= bad_pulse + 1;
      if (bus.cs_b && bitpos != 0 && win_count < 8) begin
        win_data[win_count] <= cur;
        win_len[win_count]  <= bitpos;
        win_count <= win_count + 1;
      end
    end
    if (!bus.cs_b) begin
      if (bitpos < 64) cur <= {cur[62:0], bus.mosi};
      if (bitpos == 7) first8 <= {cur[6:0], bus.mosi};
      bitpos <= bitpos + 1;
      if (bitpos >= 8 && first8 == 8'h05) bus.miso <= (bitpos % 8 == 7) && (bitpos / 8 <= wip_bytes);
      else bus.miso <= 1'b0;
    end else begin
      bitpos   <= 0;
      cur      <= '0;
      first8   <= '0;
      bus.miso <= 1'b0;
    end
  end

  assign bus2.miso = 1'b1;
  assign bus2.din  = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    @(posedge clk); clr = 1'b1;
    @(posedge clk); clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_start(input logic er, input logic [23:0] a, input logic [8:0] len);
    bus.erase = er; bus.addrin = a; bus.length = len; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input int maxc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (bus.done || bus.err) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    ram[0] = 8'hC0; ram[1] = 8'hFF; ram[2] = 8'hEE; ram[3] = 8'h00;
    bus.start = 1'b0; bus.erase = 1'b0; bus.addrin = '0; bus.length = '0;
    bus2.start = 1'b0; bus2.erase = 1'b1; bus2.addrin = 24'h010000; bus2.length = 9'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs_b", bus.cs_b, 1);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_data_req", bus.data_req, 0);
    chk("rst_data_addr", bus.data_addr, 0);
    chk("rst2_cs_b", bus2.cs_b, 1);

    // Page program of 3 bytes, with a second start while busy.
    do_clear();
    wip_bytes = 5;
    do_start(1'b0, 24'h021700, 9'd3);
    chk("prog_busy", bus.busy, 1);
    repeat (20) @(negedge clk);
    do_start(1'b1, 24'h123456, 9'd5);
    wait_end(400, cyc);
    chk("prog_finished", cyc > 0, 1);
    chk("prog_done_pulse", bus.done, 1);
    chk("prog_busy_clear", bus.busy, 0);
    chk("prog_cs_high", bus.cs_b, 1);
    repeat (3) @(negedge clk);
    chk("prog_windows", win_count, 3);
    chk("prog_wren_len", win_len[0], 8);
    chk("prog_wren_data", win_data[0], 64'h06);
    chk("prog_cmd_len", win_len[1], 56);
    chk("prog_cmd_data", win_data[1], 64'h02021700C0FFEE);
    chk("prog_poll_len", win_len[2], 56);
    chk("prog_poll_data", win_data[2], 64'h05000000000000);
    chk("prog_req_count", req_count, 3);
    chk("prog_req_addr0", req_addr[0], 0);
    chk("prog_req_addr1", req_addr[1], 1);
    chk("prog_req_addr2", req_addr[2], 2);
    chk("prog_done_count", done_count, 1);
    chk("prog_err_count", err_count, 0);

    // Sector erase.
    do_clear();
    wip_bytes = 2;
    do_start(1'b1, 24'h030000, 9'd0);
    wait_end(400, cyc);
    chk("erase_latency", cyc, 80);
    chk("erase_done_pulse", bus.done, 1);
    repeat (3) @(negedge clk);
    chk("erase_windows", win_count, 3);
    chk("erase_wren_data", win_data[0], 64'h06);
    chk("erase_cmd_len", win_len[1], 32);
    chk("erase_cmd_data", win_data[1], 64'hD8030000);
    chk("erase_poll_len", win_len[2], 32);
    chk("erase_poll_data", win_data[2], 64'h05000000);
    chk("erase_req_count", req_count, 0);
    chk("erase_done_count", done_count, 1);

    // Rejected lengths.
    do_clear();
    do_start(1'b0, 24'h000100, 9'd0);
    chk("len0_err", bus.err, 1);
    chk("len0_busy", bus.busy, 0);
    @(negedge clk);
    chk("len0_err_single", bus.err, 0);
    do_start(1'b0, 24'h000100, 9'd257);
    chk("len257_err", bus.err, 1);
    chk("len257_busy", bus.busy, 0);
    repeat (10) @(negedge clk);
    chk("len_bad_no_cs", win_count, 0);
    chk("len_bad_err_count", err_count, 2);
    chk("len_bad_done_count", done_count, 0);

    // Reset in the middle of data byte 1.
    do_clear();
    wip_bytes = 0;
    do_start(1'b0, 24'h004400, 9'd3);
    cyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_count >= 2) begin cyc = k; break; end
    end
    chk("rst_mid_reached", cyc >= 0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cs_b", bus.cs_b, 1);
    chk("rst_mid_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_mid_req_count", req_count, 2);
    chk("rst_mid_no_done", done_count, 0);
    chk("rst_mid_no_err", err_count, 0);
    wip_bytes = 1;
    do_start(1'b1, 24'h050000, 9'd0);
    wait_end(400, cyc);
    chk("after_rst_done", bus.done, 1);
    repeat (2) @(negedge clk);
    chk("after_rst_done_count", done_count, 1);
    chk("pulse_rules", bad_pulse, 0);

    // Poll timeout on the POLL_LIMIT=4 instance with WIP held high.
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      chk("timeout_no_done", bus2.done, 0);
      if (bus2.err) begin cyc = k; break; end
    end
    chk("timeout_latency", cyc, 88);
    chk("timeout_cs_b", bus2.cs_b, 1);
    chk("timeout_busy", bus2.busy, 0);
    @(negedge clk);
    chk("timeout_err_single", bus2.err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
